// File: rtl/gpio_pkg.sv
// -----------------------------------------------------------------------------
// gpio_pkg
// Shared definitions for the Wishbone GPIO peripheral: the width of the
// word-offset field decoded from the bus address and the register map
// offsets used by the top level and the testbench.
// Contents:
//    GPIO_OFFSET_W  width of the decoded word offset (address bits [4:2])
//    gpioReg_t      enumerated register offsets
// -----------------------------------------------------------------------------
package gpio_pkg;

   localparam int GPIO_OFFSET_W = 3;

   // Word offsets of the peripheral registers. OSET/OCLR only do something
   // when the set/clear feature is built in; otherwise they behave like RSVD.
   typedef enum logic [GPIO_OFFSET_W-1:0] {
      GPIO_IN   = 3'd0,
      GPIO_OUT  = 3'd1,
      GPIO_MASK = 3'd2,
      GPIO_PEND = 3'd3,
      GPIO_EDGE = 3'd4,
      GPIO_OSET = 3'd5,
      GPIO_OCLR = 3'd6,
      GPIO_RSVD = 3'd7
   } gpioReg_t;

endpackage

// File: rtl/gpio_debounce.sv
// -----------------------------------------------------------------------------
// gpio_debounce
// One input channel: a two-flop synchroniser followed by a stability counter.
// The debounced output only follows the synchronised pin once the pin has
// disagreed with it for 2^DEB_BITS consecutive cycles, so shorter glitches
// are swallowed.
// Ports:
//    clk     system clock
//    reset   asynchronous active-high reset
//    pinIn   raw asynchronous pin
//    debOut  debounced, clock-domain-safe pin value
// -----------------------------------------------------------------------------
module gpio_debounce
   import gpio_pkg::*;
#(
   parameter int DEB_BITS = 14
) (
   input  logic clk,
   input  logic reset,
   input  logic pinIn,
   output logic debOut
);

   logic                syncStage1;
   logic                syncStage2;
   logic [DEB_BITS-1:0] stableCount;

   // The synchroniser brings the pin into the clock domain. The counter
   // measures how long the synchronised value has disagreed with the accepted
   // value; any agreement restarts the measurement. When the counter has
   // reached its all-ones value and the disagreement persists, the new value
   // is accepted and the counter starts over.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         syncStage1  <= 1'b0;
         syncStage2  <= 1'b0;
         stableCount <= '0;
         debOut      <= 1'b0;
      end else begin
         syncStage1 <= pinIn;
         syncStage2 <= syncStage1;
         if (syncStage2 == debOut) begin
            stableCount <= '0;
         end else if (stableCount == '1) begin
            debOut      <= syncStage2;
            stableCount <= '0;
         end else begin
            stableCount <= stableCount + 1'b1;
         end
      end
   end

endmodule

// File: rtl/wb_gpio_irq.sv
// -----------------------------------------------------------------------------
// wb_gpio_irq
// Wishbone slave GPIO block with N_IN debounced inputs, N_OUT registered
// outputs, per-input edge detection with selectable polarity, a write-1-to-
// clear pending register, a per-bit interrupt mask and one registered level
// interrupt.
// Register map (word offset = wb_adr_i[4:2]), unused upper bits read 0:
//    0 IN   (ro)  debounced inputs
//    1 OUT  (rw)  output pins
//    2 MASK (rw)  1 = interrupt enabled
//    3 PEND (w1c) latched edge events
//    4 EDGE (rw)  1 = rising edge, 0 = falling edge
//    5 OUT_SET / 6 OUT_CLR when GPIO_OUT_SETCLR_EN is defined, else like 7
//    7 reserved: reads 0, writes ignored
// Build option: define GPIO_OUT_SETCLR_EN to enable the OUT_SET/OUT_CLR
// registers.
// Ports:
//    clk, reset                       clock, asynchronous active-high reset
//    wb_stb_i, wb_cyc_i, wb_we_i      Wishbone request qualifiers
//    wb_adr_i, wb_sel_i, wb_dat_i     address (only [4:2] used), byte selects
//                                     (ignored), write data
//    wb_dat_o, wb_ack_o               registered read data, acknowledge
//    intr                             level interrupt to the CPU
//    gpio_in, gpio_out                raw pins in, registered pins out
// -----------------------------------------------------------------------------
module wb_gpio_irq
   import gpio_pkg::*;
#(
   parameter int N_IN     = 13,
   parameter int N_OUT    = 7,
   parameter int DEB_BITS = 14
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wb_stb_i,
   input  logic              wb_cyc_i,
   input  logic              wb_we_i,
   input  logic [31:0]       wb_adr_i,
   input  logic [3:0]        wb_sel_i,
   input  logic [31:0]       wb_dat_i,
   output logic [31:0]       wb_dat_o,
   output logic              wb_ack_o,
   output logic              intr,
   input  logic [N_IN-1:0]   gpio_in,
   output logic [N_OUT-1:0]  gpio_out
);

   logic [N_IN-1:0]  debIn;
   logic [N_IN-1:0]  inReg;
   logic [N_IN-1:0]  maskReg;
   logic [N_IN-1:0]  pendReg;
   logic [N_IN-1:0]  edgeReg;
   logic [N_IN-1:0]  edgeEvent;
   logic [N_IN-1:0]  pendClear;
   logic [N_OUT-1:0] outReg;
   logic             ackReg;
   logic             accessStart;
   logic             writeStart;
   gpioReg_t         regSel;
   logic [31:0]      readData;
   logic             unusedBusBits;

   // Byte selects and the address bits outside [4:2] carry no meaning here;
   // folding them into one signal documents that they are deliberately ignored.
   assign unusedBusBits = ^{wb_sel_i, wb_adr_i[31:5], wb_adr_i[1:0]};

   // An access is accepted on the edge where the request is seen with the
   // internal ack low; the ack that follows is qualified by the live request
   // so it is exactly one cycle wide and a held request is served every
   // second cycle.
   assign regSel      = gpioReg_t'(wb_adr_i[4:2]);
   assign accessStart = wb_stb_i & wb_cyc_i & ~ackReg;
   assign writeStart  = accessStart & wb_we_i;
   assign wb_ack_o    = wb_stb_i & wb_cyc_i & ackReg;
   assign gpio_out    = outReg;

   // One debouncer per input pin.
   for (genvar i = 0; i < N_IN; i++) begin : genDebounce
      gpio_debounce #(
         .DEB_BITS(DEB_BITS)
      ) debounceInst (
         .clk    (clk),
         .reset  (reset),
         .pinIn  (gpio_in[i]),
         .debOut (debIn[i])
      );
   end

   // inReg is the debounced value one cycle late; comparing the two gives a
   // one-cycle event in the direction selected by EDGE. Because the event only
   // depends on a change of the debounced value, rewriting EDGE alone never
   // produces one. W1C bits are only taken from an accepted PEND write.
   assign edgeEvent = (edgeReg & debIn & ~inReg) | (~edgeReg & ~debIn & inReg);
   assign pendClear = (writeStart && (regSel == GPIO_PEND)) ? wb_dat_i[N_IN-1:0] : '0;

   // Read multiplexer: every register is zero-extended to the bus width and
   // all undefined or write-only offsets read back as zero.
   always_comb begin
      readData = '0;
      case (regSel)
         GPIO_IN:   readData[N_IN-1:0]  = inReg;
         GPIO_OUT:  readData[N_OUT-1:0] = outReg;
         GPIO_MASK: readData[N_IN-1:0]  = maskReg;
         GPIO_PEND: readData[N_IN-1:0]  = pendReg;
         GPIO_EDGE: readData[N_IN-1:0]  = edgeReg;
         default:   readData = '0;
      endcase
   end

   // Bus side: the ack register, the read data capture and all writable
   // control registers update on the same edge that accepts the access, so a
   // write is visible in the same cycle its ack is.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ackReg   <= 1'b0;
         wb_dat_o <= '0;
         outReg   <= '0;
         maskReg  <= '0;
         edgeReg  <= '0;
      end else begin
         ackReg <= wb_stb_i & wb_cyc_i & ~ackReg;
         if (accessStart) begin
            wb_dat_o <= readData;
         end
         if (writeStart) begin
            case (regSel)
               GPIO_OUT:  outReg  <= wb_dat_i[N_OUT-1:0];
               GPIO_MASK: maskReg <= wb_dat_i[N_IN-1:0];
               GPIO_EDGE: edgeReg <= wb_dat_i[N_IN-1:0];
`ifdef GPIO_OUT_SETCLR_EN
               GPIO_OSET: outReg  <= outReg | wb_dat_i[N_OUT-1:0];
               GPIO_OCLR: outReg  <= outReg & ~wb_dat_i[N_OUT-1:0];
`endif
               default:   ;
            endcase
         end
      end
   end

   // Event side: delayed debounced inputs, the pending register and the
   // registered interrupt. A new event is ORed in after the clear is applied
   // so an event always wins over a simultaneous W1C of the same bit.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         inReg   <= '0;
         pendReg <= '0;
         intr    <= 1'b0;
      end else begin
         inReg   <= debIn;
         pendReg <= (pendReg & ~pendClear) | edgeEvent;
         intr    <= |(pendReg & maskReg);
      end
   end

endmodule

// File: tb/tb_wb_gpio_irq.sv
// -----------------------------------------------------------------------------
// tb_wb_gpio_irq
// Self-checking bench for wb_gpio_irq built with DEB_BITS=4, so a pin change
// reaches IN 18 cycles after the first synchroniser flop captures it.
// -----------------------------------------------------------------------------
module tb_wb_gpio_irq;
   import gpio_pkg::*;

   localparam int N_IN     = 13;
   localparam int N_OUT    = 7;
   localparam int DEB_BITS = 4;
   localparam logic [31:0] IN_MASK  = 32'h0000_1FFF;
   localparam logic [31:0] OUT_MASK = 32'h0000_007F;

   logic             clk;
   logic             reset;
   logic             wbStb;
   logic             wbCyc;
   logic             wbWe;
   logic [31:0]      wbAdr;
   logic [3:0]       wbSel;
   logic [31:0]      wbDatIn;
   logic [31:0]      wbDatOut;
   logic             wbAck;
   logic             intr;
   logic [N_IN-1:0]  gpioIn;
   logic [N_OUT-1:0] gpioOut;

   int checkCount;
   int errorCount;

   // Reference model state: plain register images updated from the register
   // map rules, independent of how the RTL is built.
   logic [31:0] modelIn;
   logic [31:0] modelOut;
   logic [31:0] modelMask;
   logic [31:0] modelPend;
   logic [31:0] modelEdge;

   typedef struct {
      logic        isWrite;
      logic [2:0]  offset;
      logic [31:0] data;
      logic [31:0] expected;
   } vector_t;

   vector_t vectors[18];

   wb_gpio_irq #(
      .N_IN     (N_IN),
      .N_OUT    (N_OUT),
      .DEB_BITS (DEB_BITS)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .wb_stb_i (wbStb),
      .wb_cyc_i (wbCyc),
      .wb_we_i  (wbWe),
      .wb_adr_i (wbAdr),
      .wb_sel_i (wbSel),
      .wb_dat_i (wbDatIn),
      .wb_dat_o (wbDatOut),
      .wb_ack_o (wbAck),
      .intr     (intr),
      .gpio_in  (gpioIn),
      .gpio_out (gpioOut)
   );

   // 100 MHz-style free-running clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Safety net so the run always ends even if something stalls.
   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog expired actual=running required=finished");
      $fatal(1, "[TB] watchdog");
   end

   // Compare one value and keep the running counts.
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, actual, expected);
      end
   endtask

   // One complete Wishbone access, entered at a falling edge. The ack edge is
   // the next rising edge; the task returns at a falling edge two cycles later
   // with the bus idle. Unused address bits and byte selects are randomised.
   task automatic applyStimulus(input logic isWrite, input logic [2:0] offset,
                                input logic [31:0] wdata, output logic [31:0] rdata);
      wbStb   = 1'b1;
      wbCyc   = 1'b1;
      wbWe    = isWrite;
      wbAdr   = {27'($urandom), offset, 2'($urandom)};
      wbSel   = 4'($urandom);
      wbDatIn = wdata;
      @(posedge clk);
      #1;
      checkOutput("ackOnAccess", {31'h0, wbAck}, 32'h1);
      rdata = wbDatOut;
      @(negedge clk);
      wbStb = 1'b0;
      wbCyc = 1'b0;
      wbWe  = 1'b0;
      #1;
      checkOutput("ackDropsWithStb", {31'h0, wbAck}, 32'h0);
      @(posedge clk);
      @(negedge clk);
   endtask

   // Register-map rules for the reference model.
   function automatic void modelWrite(input logic [2:0] offset, input logic [31:0] data);
      case (offset)
         3'd1: modelOut  = data & OUT_MASK;
         3'd2: modelMask = data & IN_MASK;
         3'd3: modelPend = modelPend & ~data;
         3'd4: modelEdge = data & IN_MASK;
`ifdef GPIO_OUT_SETCLR_EN
         3'd5: modelOut  = (modelOut | data) & OUT_MASK;
         3'd6: modelOut  = modelOut & ~data;
`endif
         default: ;
      endcase
   endfunction

   function automatic logic [31:0] modelRead(input logic [2:0] offset);
      case (offset)
         3'd0:    return modelIn;
         3'd1:    return modelOut;
         3'd2:    return modelMask;
         3'd3:    return modelPend;
         3'd4:    return modelEdge;
         default: return 32'h0;
      endcase
   endfunction

   // A settled pin change: every pin that moved in the direction its EDGE
   // bit selects latches a pending bit.
   function automatic void modelPins(input logic [31:0] newPins);
      for (int b = 0; b < N_IN; b++) begin
         if (newPins[b] != modelIn[b]) begin
            if ((modelEdge[b] == 1'b1 && newPins[b] == 1'b1) ||
                (modelEdge[b] == 1'b0 && newPins[b] == 1'b0)) begin
               modelPend[b] = 1'b1;
            end
         end
      end
      modelIn = newPins & IN_MASK;
   endfunction

   logic [31:0] rd;
   logic [31:0] expectOut;
   logic [31:0] newPins;
   logic [2:0]  randOffset;
   logic [31:0] randData;
   int          op;

   initial begin
      checkCount = 0;
      errorCount = 0;
      reset   = 1'b1;
      wbStb   = 1'b0;
      wbCyc   = 1'b0;
      wbWe    = 1'b0;
      wbAdr   = '0;
      wbSel   = '0;
      wbDatIn = '0;
      gpioIn  = '0;

      vectors[0]  = '{1'b1, 3'd1, 32'hFFFF_FFFF, 32'h0};
      vectors[1]  = '{1'b0, 3'd1, 32'h0,         32'h0000_007F};
      vectors[2]  = '{1'b1, 3'd2, 32'hFFFF_FFFF, 32'h0};
      vectors[3]  = '{1'b0, 3'd2, 32'h0,         32'h0000_1FFF};
      vectors[4]  = '{1'b1, 3'd2, 32'h0,         32'h0};
      vectors[5]  = '{1'b0, 3'd2, 32'h0,         32'h0};
      vectors[6]  = '{1'b1, 3'd4, 32'h0000_ABCD, 32'h0};
      vectors[7]  = '{1'b0, 3'd4, 32'h0,         32'h0000_0BCD};
      vectors[8]  = '{1'b1, 3'd0, 32'h0000_FFFF, 32'h0};
      vectors[9]  = '{1'b0, 3'd0, 32'h0,         32'h0};
      vectors[10] = '{1'b1, 3'd7, 32'hFFFF_FFFF, 32'h0};
      vectors[11] = '{1'b0, 3'd7, 32'h0,         32'h0};
      vectors[12] = '{1'b0, 3'd5, 32'h0,         32'h0};
      vectors[13] = '{1'b0, 3'd6, 32'h0,         32'h0};
      vectors[14] = '{1'b1, 3'd4, 32'h0,         32'h0};
      vectors[15] = '{1'b0, 3'd3, 32'h0,         32'h0};
      vectors[16] = '{1'b1, 3'd1, 32'h0,         32'h0};
      vectors[17] = '{1'b0, 3'd1, 32'h0,         32'h0};

      // Power-on reset values.
      repeat (3) @(negedge clk);
      reset = 1'b0;
      checkOutput("resetGpioOut", {25'h0, gpioOut}, 32'h0);
      checkOutput("resetDatOut", wbDatOut, 32'h0);
      checkOutput("resetAck", {31'h0, wbAck}, 32'h0);
      checkOutput("resetIntr", {31'h0, intr}, 32'h0);

      // Put something in OUT, then hit reset in the middle of a read.
      applyStimulus(1'b1, GPIO_OUT, 32'h2A, rd);
      checkOutput("preResetOut", {25'h0, gpioOut}, 32'h2A);
      wbStb = 1'b1;
      wbCyc = 1'b1;
      wbWe  = 1'b0;
      wbAdr = {27'h0, GPIO_IN, 2'b00};
      #2 reset = 1'b1;
      #1 checkOutput("asyncClearOut", {25'h0, gpioOut}, 32'h0);
      @(posedge clk);
      #1 checkOutput("noAckUnderReset", {31'h0, wbAck}, 32'h0);
      @(negedge clk);
      wbStb = 1'b0;
      wbCyc = 1'b0;
      reset = 1'b0;
      applyStimulus(1'b0, GPIO_IN, 32'h0, rd);
      checkOutput("postResetIn", rd, 32'h0);
      applyStimulus(1'b0, GPIO_OUT, 32'h0, rd);
      checkOutput("postResetOut", rd, 32'h0);
      applyStimulus(1'b0, GPIO_PEND, 32'h0, rd);
      checkOutput("postResetPend", rd, 32'h0);
      checkOutput("postResetIntr", {31'h0, intr}, 32'h0);

      // OUT write takes effect on the ack edge; a held request is acked on
      // alternate cycles only.
      wbStb   = 1'b1;
      wbCyc   = 1'b1;
      wbWe    = 1'b1;
      wbAdr   = {27'h0, GPIO_OUT, 2'b00};
      wbDatIn = 32'h55;
      #1 checkOutput("outBeforeAckEdge", {25'h0, gpioOut}, 32'h0);
      @(posedge clk);
      #1;
      checkOutput("outOnAckEdge", {25'h0, gpioOut}, 32'h55);
      checkOutput("ackFirstCycle", {31'h0, wbAck}, 32'h1);
      @(posedge clk);
      #1 checkOutput("ackSecondCycle", {31'h0, wbAck}, 32'h0);
      @(posedge clk);
      #1 checkOutput("ackBackToBack", {31'h0, wbAck}, 32'h1);
      @(negedge clk);
      wbStb = 1'b0;
      wbCyc = 1'b0;
      wbWe  = 1'b0;
      @(posedge clk);
      @(negedge clk);
      applyStimulus(1'b0, GPIO_OUT, 32'h0, rd);
      checkOutput("readOut55", rd, 32'h0000_0055);

      // Register map table.
      for (int v = 0; v < 18; v++) begin
         applyStimulus(vectors[v].isWrite, vectors[v].offset, vectors[v].data, rd);
         if (!vectors[v].isWrite) begin
            checkOutput($sformatf("table%0d", v), rd, vectors[v].expected);
         end
      end
      checkOutput("tableIntr", {31'h0, intr}, 32'h0);

      // A 10-cycle glitch is shorter than the debounce window.
      gpioIn[0] = 1'b1;
      repeat (10) @(negedge clk);
      gpioIn[0] = 1'b0;
      repeat (30) @(negedge clk);
      applyStimulus(1'b0, GPIO_IN, 32'h0, rd);
      checkOutput("glitchIn", rd, 32'h0);
      applyStimulus(1'b0, GPIO_PEND, 32'h0, rd);
      checkOutput("glitchPend", rd, 32'h0);

      // Rising edge on pin 0: IN must still read 0 after 17 cycles and 1
      // after 18; intr follows PEND one cycle later.
      applyStimulus(1'b1, GPIO_EDGE, 32'h1, rd);
      applyStimulus(1'b1, GPIO_MASK, 32'h1, rd);
      gpioIn[0] = 1'b1;
      repeat (18) @(negedge clk);
      checkOutput("intrBeforeEvent", {31'h0, intr}, 32'h0);
      applyStimulus(1'b0, GPIO_IN, 32'h0, rd);
      checkOutput("inAt17Cycles", rd, 32'h0);
      checkOutput("intrAfterEvent", {31'h0, intr}, 32'h1);
      applyStimulus(1'b0, GPIO_IN, 32'h0, rd);
      checkOutput("inAfterSettle", rd, 32'h1);
      applyStimulus(1'b0, GPIO_PEND, 32'h0, rd);
      checkOutput("pendRising", rd, 32'h1);

      // W1C drops the interrupt.
      applyStimulus(1'b1, GPIO_PEND, 32'h1, rd);
      applyStimulus(1'b0, GPIO_PEND, 32'h0, rd);
      checkOutput("pendCleared", rd, 32'h0);
      checkOutput("intrCleared", {31'h0, intr}, 32'h0);

      // Falling edge with rising polarity selected: nothing latches.
      gpioIn[0] = 1'b0;
      repeat (25) @(negedge clk);
      applyStimulus(1'b0, GPIO_PEND, 32'h0, rd);
      checkOutput("pendNoFalling", rd, 32'h0);
      applyStimulus(1'b0, GPIO_IN, 32'h0, rd);
      checkOutput("inFallen", rd, 32'h0);
      checkOutput("intrNoFalling", {31'h0, intr}, 32'h0);

      // Collision on bit 2: latch it with a rising edge, switch to falling
      // polarity, then land a W1C on exactly the edge the falling event fires.
      applyStimulus(1'b1, GPIO_EDGE, 32'h4, rd);
      applyStimulus(1'b1, GPIO_MASK, 32'h4, rd);
      gpioIn[2] = 1'b1;
      repeat (25) @(negedge clk);
      applyStimulus(1'b0, GPIO_PEND, 32'h0, rd);
      checkOutput("pendBit2Set", rd, 32'h4);
      checkOutput("intrBit2Set", {31'h0, intr}, 32'h1);
      applyStimulus(1'b1, GPIO_EDGE, 32'h0, rd);
      gpioIn[2] = 1'b0;
      repeat (18) @(negedge clk);
      applyStimulus(1'b1, GPIO_PEND, 32'h4, rd);
      checkOutput("intrHeldOnCollision", {31'h0, intr}, 32'h1);
      applyStimulus(1'b0, GPIO_PEND, 32'h0, rd);
      checkOutput("pendSetWins", rd, 32'h4);
      applyStimulus(1'b1, GPIO_PEND, 32'h4, rd);
      applyStimulus(1'b0, GPIO_PEND, 32'h0, rd);
      checkOutput("pendBit2Cleared", rd, 32'h0);
      checkOutput("intrBit2Cleared", {31'h0, intr}, 32'h0);

      // Set/clear aliases of OUT.
      applyStimulus(1'b1, GPIO_OUT, 32'h0F, rd);
      applyStimulus(1'b1, GPIO_OSET, 32'h30, rd);
      applyStimulus(1'b1, GPIO_OCLR, 32'h03, rd);
`ifdef GPIO_OUT_SETCLR_EN
      expectOut = 32'h3C;
`else
      expectOut = 32'h0F;
`endif
      applyStimulus(1'b0, GPIO_OUT, 32'h0, rd);
      checkOutput("setClrOut", rd, expectOut);
      checkOutput("setClrPins", {25'h0, gpioOut}, expectOut);

      // Randomised traffic against the reference model from a known start.
      applyStimulus(1'b1, GPIO_OUT, 32'h0, rd);
      applyStimulus(1'b1, GPIO_MASK, 32'h0, rd);
      applyStimulus(1'b1, GPIO_EDGE, 32'h0, rd);
      applyStimulus(1'b1, GPIO_PEND, 32'hFFFF_FFFF, rd);
      modelIn   = 32'h0;
      modelOut  = 32'h0;
      modelMask = 32'h0;
      modelPend = 32'h0;
      modelEdge = 32'h0;
      for (int n = 0; n < 80; n++) begin
         op = $urandom_range(0, 3);
         randOffset = 3'($urandom);
         randData   = $urandom;
         case (op)
            0: begin
               applyStimulus(1'b1, randOffset, randData, rd);
               modelWrite(randOffset, randData);
            end
            1: begin
               applyStimulus(1'b0, randOffset, 32'h0, rd);
               checkOutput($sformatf("randRead%0d_off%0d", n, randOffset), rd, modelRead(randOffset));
            end
            2: begin
               newPins = {19'h0, 13'($urandom)};
               gpioIn  = newPins[N_IN-1:0];
               modelPins(newPins);
               repeat (25) @(negedge clk);
            end
            default: begin
               checkOutput($sformatf("randIntr%0d", n), {31'h0, intr},
                           {31'h0, |(modelPend & modelMask)});
               checkOutput($sformatf("randPins%0d", n), {25'h0, gpioOut}, modelOut);
            end
         endcase
      end
      applyStimulus(1'b0, GPIO_PEND, 32'h0, rd);
      checkOutput("randFinalPend", rd, modelPend);
      applyStimulus(1'b0, GPIO_IN, 32'h0, rd);
      checkOutput("randFinalIn", rd, modelIn);

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule

// File: doc/wb_gpio_irq.md
Name: wb_gpio_irq

Overview:
- Parametrised Wishbone GPIO peripheral: N_IN debounced inputs, N_OUT registered outputs.
- Adds per-input edge detection, a pending register with write-1-to-clear, per-bit interrupt mask and selectable edge polarity.
- Sits on the SoC Wishbone bus as a slave and drives a single level interrupt line to the CPU interrupt controller.

Parameters:
- N_IN, 13, number of input pins (1..32).
- N_OUT, 7, number of output pins (1..32).
- DEB_BITS, 14, debounce counter width; input must be stable 2^DEB_BITS cycles to be accepted (2..20).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- wb_stb_i  in  1  Wishbone strobe.
- wb_cyc_i  in  1  Wishbone cycle.
- wb_we_i  in  1  write enable.
- wb_adr_i  in  32  byte address; only [4:2] decoded.
- wb_sel_i  in  4  byte selects; ignored, all accesses are full-word.
- wb_dat_i  in  32  write data.
- wb_dat_o  out  32  read data, registered.
- wb_ack_o  out  1  acknowledge.
- intr  out  1  level interrupt, high while any enabled pending bit is set.
- gpio_in  in  N_IN  raw asynchronous pin inputs.
- gpio_out  out  N_OUT  registered pin outputs.

Behaviour:
- Reset (asynchronous, active-high) clears every register, every debounce counter and every synchroniser. Resulting values: gpio_out=0, wb_dat_o=0, ack=0, intr=0.
- A reset mid-transfer aborts the access. No ack is produced for an access interrupted by reset.
- Register map (word offsets, adr[4:2]); unused upper bits read 0:
  - 0 IN: read-only, debounced input value.
  - 1 OUT: read/write.
  - 2 MASK: read/write, 1 = interrupt enabled.
  - 3 PEND: read; writing 1 clears the bit, writing 0 has no effect.
  - 4 EDGE: read/write, 1 = rising edge, 0 = falling edge.
  - 5..7: read 0, writes ignored (see optional feature).
- Handshake:
  - internal ack register is set one cycle after stb&cyc is seen with ack low.
  - wb_ack_o = stb & cyc & ack, so an ack is a one-cycle pulse.
  - Back-to-back requests are acked every second cycle.
  - Write side effects take effect on the same edge that raises ack.
  - wb_dat_o is loaded on that same edge.
- Debounce, per bit:
  - 2-FF synchroniser feeds the debounce logic.
  - Counter clears whenever sync == deb.
  - While sync != deb the counter increments.
  - When the counter equals 2^DEB_BITS-1 and the bits still differ, deb <= sync and the counter clears.
  - A pin change is visible in IN 2 + 2^DEB_BITS cycles after it is registered at the first flop.
  - A glitch shorter than 2^DEB_BITS cycles never reaches deb.
- Edge detect, per bit:
  - deb_q is deb delayed by one cycle.
  - Event = EDGE ? (deb & ~deb_q) : (~deb & deb_q).
  - An event sets the PEND bit regardless of MASK.
- Simultaneous event and W1C of the same bit: set wins, bit remains 1.
- intr is registered: it becomes |(PEND & MASK) one cycle after PEND or MASK changes.
- Changing EDGE does not itself generate events.

Optional Feature:
- Macro GPIO_OUT_SETCLR_EN.
- With it defined:
  - offset 5 is OUT_SET: gpio_out <= gpio_out | wdata.
  - offset 6 is OUT_CLR: gpio_out <= gpio_out & ~wdata.
  - Both read 0.
- Without it, offsets 5 and 6 behave like 7: read 0, writes ignored, still acked.

Decomposition:
- Package gpio_pkg holds:
  - register offset constants (GPIO_IN, GPIO_OUT, GPIO_MASK, GPIO_PEND, GPIO_EDGE, GPIO_OSET, GPIO_OCLR).
  - the 3-bit offset width.
- Sub-module gpio_debounce:
  - one channel: synchroniser, counter, deb output, parametrised by DEB_BITS.
  - instantiated N_IN times with a generate loop.

Test Plan (DEB_BITS=4):
- Reset asserted mid-read -> no ack; after release, read IN=0, OUT=0, PEND=0, and intr=0.
- Write OUT=0x55 -> gpio_out=0x55 on the ack edge; read OUT returns 0x00000055; ack pulses for exactly 1 cycle per access.
- Debounce:
  - gpio_in[0] pulsed high for 10 cycles -> IN stays 0, PEND stays 0.
  - gpio_in[0] held high -> IN[0]=1 after 18 cycles.
- Edge and interrupt:
  - EDGE=1, MASK=0x1, rising edge on bit 0 -> PEND=0x1 and intr=1 on the next cycle.
  - W1C PEND=0x1 -> intr=0.
  - Falling edge on bit 0 -> no new pending bit.
- Same-cycle collision: W1C PEND bit 2 issued on the same cycle a bit-2 event fires -> PEND[2] stays 1 and intr stays high.
- Optional feature:
  - With GPIO_OUT_SETCLR_EN, OUT=0x0F, write 0x30 to offset 5 then 0x03 to offset 6 -> OUT=0x3C.
  - Without it, the same sequence leaves OUT=0x0F.
